// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for mem_port_arbiter.
//   arb_state_e : arbiter FSM states
//   mid_t       : master id (0 = CPU, 1 = DMA/debug loader)
//   MAX_RAM_LAT : largest supported RAM latency
//   lat_cnt_t   : latency down-counter type, sized from MAX_RAM_LAT
package mem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_e;

   typedef logic mid_t;

   localparam int MAX_RAM_LAT = 4;
   // The counter only ever holds RAM_LAT-1, so values 0..MAX_RAM_LAT-1 suffice
   localparam int LAT_CNT_W   = (MAX_RAM_LAT > 1) ? $clog2(MAX_RAM_LAT) : 1;

   typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle for the two requesters plus the
// RAM port.
//   slave  : arbiter side (takes requests, drives gnt/rvalid/rdata and RAM port)
//   master : requester + RAM-model side
// Optional: MEM_ARB_LOCK_EN adds m0_lock / m1_lock.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req, m0_we, m0_signed_ext, m0_gnt, m0_rvalid;
   logic [ADDR_W-1:0] m0_addr;
   logic [1:0]        m0_mask;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;

   logic              m1_req, m1_we, m1_signed_ext, m1_gnt, m1_rvalid;
   logic [ADDR_W-1:0] m1_addr;
   logic [1:0]        m1_mask;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;

`ifdef MEM_ARB_LOCK_EN
   logic              m0_lock, m1_lock;
`endif

   logic              ram_we, ram_signed_ext;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        ram_mask;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   modport slave (
`ifdef MEM_ARB_LOCK_EN
      input  m0_lock, m1_lock,
`endif
      input  m0_req, m0_we, m0_addr, m0_mask, m0_signed_ext, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_mask, m1_signed_ext, m1_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_we, ram_addr, ram_mask, ram_signed_ext, ram_wdata,
      input  ram_rdata
   );

   modport master (
`ifdef MEM_ARB_LOCK_EN
      output m0_lock, m1_lock,
`endif
      output m0_req, m0_we, m0_addr, m0_mask, m0_signed_ext, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_mask, m1_signed_ext, m1_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_we, ram_addr, ram_mask, ram_signed_ext, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin picker.
//   req[1:0] : request vector
//   last_gnt : master granted most recently (stored by the parent)
//   lock     : (MEM_ARB_LOCK_EN) ownership held by `owner`
//   owner    : (MEM_ARB_LOCK_EN) current owner id
//   gnt[1:0] : one-hot grant, zero when nothing eligible requests
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  mid_t       last_gnt,
`ifdef MEM_ARB_LOCK_EN
   input  logic       lock,
   input  mid_t       owner,
`endif
   output logic [1:0] gnt
);

   logic [1:0] elig;

   always_comb begin
      elig = req;
`ifdef MEM_ARB_LOCK_EN
      // While locked, only the owner is eligible
      if (lock) elig = req & (owner ? 2'b10 : 2'b01);
`endif
      gnt = elig;
      // Tie: the master not served last wins
      if (elig == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between the CPU (m0) and a DMA/debug
// loader (m1). One transaction at a time, held on the RAM for RAM_LAT cycles,
// completion (read data or write ack) returned to the owner as an rvalid pulse.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, gnt/rvalid/rdata, RAM port)
// Parameters: RAM_LAT (1..MAX_RAM_LAT), ADDR_W, DATA_W.
// Optional: MEM_ARB_LOCK_EN enables locked (exclusive) ownership sequences.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RAM_LAT = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic clk,
   input  logic reset,
   mem_port_arbiter_if.slave bus
);

   localparam lat_cnt_t LAT_INIT = lat_cnt_t'(RAM_LAT - 1);

   arb_state_e              state_q, state_d;
   lat_cnt_t                lat_cnt_q, lat_cnt_d;
   mid_t                    owner_q, owner_d;
   mid_t                    last_gnt_q, last_gnt_d;
   logic                    we_q, we_d;
   logic                    ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [1:0]              mask_q, mask_d;
   logic                    sext_q, sext_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [1:0]              rvalid_q, rvalid_d;
   logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
`ifdef MEM_ARB_LOCK_EN
   logic                    lock_q, lock_d;
`endif

   logic [1:0] gnt_vec;
   mid_t       win;

   rr_arbiter2 u_rr (
      .req      ({bus.m1_req, bus.m0_req}),
      .last_gnt (last_gnt_q),
`ifdef MEM_ARB_LOCK_EN
      .lock     (lock_q),
      .owner    (owner_q),
`endif
      .gnt      (gnt_vec)
   );

   assign win = gnt_vec[1];

   // Grant only in IDLE; gated by reset so nothing is offered while held in reset
   assign bus.m0_gnt = reset && (state_q == ARB_IDLE) && gnt_vec[0];
   assign bus.m1_gnt = reset && (state_q == ARB_IDLE) && gnt_vec[1];

   assign bus.ram_we         = ram_we_q;
   assign bus.ram_addr       = addr_q;
   assign bus.ram_mask       = mask_q;
   assign bus.ram_signed_ext = sext_q;
   assign bus.ram_wdata      = wdata_q;
   assign bus.m0_rvalid      = rvalid_q[0];
   assign bus.m1_rvalid      = rvalid_q[1];
   assign bus.m0_rdata       = rdata_q[0];
   assign bus.m1_rdata       = rdata_q[1];

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      sext_d     = sext_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rvalid_d   = 2'b00;
      ram_we_d   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_d     = lock_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (gnt_vec != 2'b00) begin
               owner_d    = win;
               last_gnt_d = win;
               we_d       = win ? bus.m1_we          : bus.m0_we;
               addr_d     = win ? bus.m1_addr        : bus.m0_addr;
               mask_d     = win ? bus.m1_mask        : bus.m0_mask;
               sext_d     = win ? bus.m1_signed_ext  : bus.m0_signed_ext;
               wdata_d    = win ? bus.m1_wdata       : bus.m0_wdata;
               // Write strobe only for the first ACCESS cycle
               ram_we_d   = win ? bus.m1_we          : bus.m0_we;
               lat_cnt_d  = LAT_INIT;
               state_d    = ARB_ACCESS;
`ifdef MEM_ARB_LOCK_EN
               // Unlocked owner request ends the sequence
               lock_d     = win ? bus.m1_lock : bus.m0_lock;
`endif
            end
         end
         ARB_ACCESS: begin
            if (lat_cnt_q == '0) begin
               rdata_d[owner_q]  = we_q ? '0 : bus.ram_rdata;
               rvalid_d[owner_q] = 1'b1;
               state_d           = ARB_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ARB_IDLE;
         lat_cnt_q  <= '0;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         we_q       <= 1'b0;
         ram_we_q   <= 1'b0;
         addr_q     <= '0;
         mask_q     <= '0;
         sext_q     <= 1'b0;
         wdata_q    <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         we_q       <= we_d;
         ram_we_q   <= ram_we_d;
         addr_q     <= addr_d;
         mask_q     <= mask_d;
         sext_q     <= sext_d;
         wdata_q    <= wdata_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
`ifdef MEM_ARB_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench. u1 runs with RAM_LAT=1 (reset and
// contention), u2 with RAM_LAT=2 (read, write ack, reset mid-access, lock).
// Inputs are driven right after the falling edge; outputs sampled 1ns later.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

   mem_port_arbiter #(.RAM_LAT(1), .ADDR_W(32), .DATA_W(32)) u1 (
      .clk(clk), .reset(reset), .bus(if1.slave));
   mem_port_arbiter #(.RAM_LAT(2), .ADDR_W(32), .DATA_W(32)) u2 (
      .clk(clk), .reset(reset), .bus(if2.slave));

   task automatic clr_inputs();
      if1.m0_req = 0; if1.m0_we = 0; if1.m0_addr = 0; if1.m0_mask = 0;
      if1.m0_signed_ext = 0; if1.m0_wdata = 0;
      if1.m1_req = 0; if1.m1_we = 0; if1.m1_addr = 0; if1.m1_mask = 0;
      if1.m1_signed_ext = 0; if1.m1_wdata = 0; if1.ram_rdata = 0;
      if2.m0_req = 0; if2.m0_we = 0; if2.m0_addr = 0; if2.m0_mask = 0;
      if2.m0_signed_ext = 0; if2.m0_wdata = 0;
      if2.m1_req = 0; if2.m1_we = 0; if2.m1_addr = 0; if2.m1_mask = 0;
      if2.m1_signed_ext = 0; if2.m1_wdata = 0; if2.ram_rdata = 0;
`ifdef MEM_ARB_LOCK_EN
      if1.m0_lock = 0; if1.m1_lock = 0; if2.m0_lock = 0; if2.m1_lock = 0;
`endif
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Held in reset with both requests up: everything quiet. Release: m0 first.
   task automatic test_reset();
      logic [7:0] ctl;
      clr_inputs();
      reset = 1'b0;
      if1.m0_req = 1; if1.m1_req = 1;
      if1.m0_addr = 32'hA0; if1.m1_addr = 32'hB0;
      repeat (2) nxt();
      #1;
      ctl = {if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid,
             if1.ram_we, if1.ram_signed_ext, if1.ram_mask};
      checks++;
      if (ctl !== 8'h00) begin
         errors++; $display("FAIL reset_ctl got %b want 00000000", ctl);
      end
      checks++;
      if ({if1.m0_rdata, if1.m1_rdata} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata got %h %h want 0", if1.m0_rdata, if1.m1_rdata);
      end
      checks++;
      if ({if1.ram_addr, if1.ram_wdata} !== 64'h0) begin
         errors++; $display("FAIL reset_ram got %h %h want 0", if1.ram_addr, if1.ram_wdata);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({if1.m0_gnt, if1.m1_gnt} !== 2'b10) begin
         errors++; $display("FAIL reset_first_gnt got m0=%b m1=%b want m0=1 m1=0", if1.m0_gnt, if1.m1_gnt);
      end
   endtask

   // Continues straight from test_reset: both masters keep requesting, RAM_LAT=1.
   task automatic test_contention();
      int exp_m;
      for (int i = 0; i < 8; i++) begin
         exp_m = i % 2;
         checks++;
         if ({if1.m1_gnt, if1.m0_gnt} !== (exp_m ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL cont_gnt[%0d] got m1=%b m0=%b want m%0d", i, if1.m1_gnt, if1.m0_gnt, exp_m);
         end
         if (i > 0) begin
            checks++;
            if ({if1.m1_rvalid, if1.m0_rvalid} !== (exp_m ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL cont_rvalid[%0d] got m1=%b m0=%b want m%0d", i, if1.m1_rvalid, if1.m0_rvalid, 1 - exp_m);
            end
            checks++;
            if ((exp_m ? if1.m0_rdata : if1.m1_rdata) !== 32'h1000 + i - 1) begin
               errors++; $display("FAIL cont_rdata[%0d] got %h want %h", i, exp_m ? if1.m0_rdata : if1.m1_rdata, 32'h1000 + i - 1);
            end
         end
         nxt();
         if1.ram_rdata = 32'h1000 + i;
         if (i == 7) begin if1.m0_req = 0; if1.m1_req = 0; end
         #1;
         checks++;
         if ({if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL cont_access[%0d] got gnt=%b%b rvalid=%b%b want 0", i, if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid);
         end
         nxt(); #1;
      end
      checks++;
      if ({if1.m1_rvalid, if1.m0_rvalid, if1.m1_rdata} !== {2'b10, 32'h1007}) begin
         errors++; $display("FAIL cont_last got rvalid=%b%b rdata=%h want 10 00001007", if1.m1_rvalid, if1.m0_rvalid, if1.m1_rdata);
      end
   endtask

   // m0 reads 0x100 on u2 (RAM_LAT=2): addr held 2 cycles, rvalid at T+3.
   task automatic test_single_read();
      nxt();
      if2.m0_req = 1; if2.m0_we = 0; if2.m0_addr = 32'h100;
      if2.m0_mask = 2'b10; if2.m0_signed_ext = 1;
      #1;
      checks++;
      if ({if2.m0_gnt, if2.m1_gnt} !== 2'b10) begin
         errors++; $display("FAIL rd_gnt got m0=%b m1=%b want 1 0", if2.m0_gnt, if2.m1_gnt);
      end
      for (int c = 1; c <= 2; c++) begin
         nxt();
         if2.m0_req = 0;
         if2.ram_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
         #1;
         checks++;
         if ({if2.ram_addr, if2.ram_mask, if2.ram_signed_ext, if2.ram_we} !== {32'h100, 2'b10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rd_ram[T+%0d] got addr=%h mask=%b sext=%b we=%b want 100 10 1 0", c, if2.ram_addr, if2.ram_mask, if2.ram_signed_ext, if2.ram_we);
         end
         checks++;
         if ({if2.m0_rvalid, if2.m0_gnt} !== 2'b00) begin
            errors++; $display("FAIL rd_early[T+%0d] got rvalid=%b gnt=%b want 0 0", c, if2.m0_rvalid, if2.m0_gnt);
         end
      end
      nxt(); #1;
      checks++;
      if ({if2.m0_rvalid, if2.m1_rvalid, if2.m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd_done got rvalid=%b%b rdata=%h want 10 deadbeef", if2.m0_rvalid, if2.m1_rvalid, if2.m0_rdata);
      end
      nxt(); #1;
      checks++;
      if (if2.m0_rvalid !== 1'b0) begin
         errors++; $display("FAIL rd_pulse got rvalid=%b want 0", if2.m0_rvalid);
      end
   endtask

   // m1 writes 0x55AA to 0x40: one-cycle ram_we, ack with rdata 0; m0 rdata kept.
   task automatic test_write_ack();
      if2.m1_req = 1; if2.m1_we = 1; if2.m1_addr = 32'h40; if2.m1_wdata = 32'h55AA;
      if2.ram_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({if2.m0_gnt, if2.m1_gnt} !== 2'b01) begin
         errors++; $display("FAIL wr_gnt got m0=%b m1=%b want 0 1", if2.m0_gnt, if2.m1_gnt);
      end
      nxt(); if2.m1_req = 0; #1;
      checks++;
      if ({if2.ram_we, if2.ram_addr, if2.ram_wdata} !== {1'b1, 32'h40, 32'h55AA}) begin
         errors++; $display("FAIL wr_first got we=%b addr=%h wdata=%h want 1 40 55aa", if2.ram_we, if2.ram_addr, if2.ram_wdata);
      end
      nxt(); #1;
      checks++;
      if ({if2.ram_we, if2.ram_wdata} !== {1'b0, 32'h55AA}) begin
         errors++; $display("FAIL wr_second got we=%b wdata=%h want 0 55aa", if2.ram_we, if2.ram_wdata);
      end
      nxt(); #1;
      checks++;
      if ({if2.m1_rvalid, if2.m0_rvalid, if2.m1_rdata} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL wr_ack got rvalid m1=%b m0=%b rdata=%h want 1 0 0", if2.m1_rvalid, if2.m0_rvalid, if2.m1_rdata);
      end
      checks++;
      if (if2.m0_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_m0_hold got %h want deadbeef", if2.m0_rdata);
      end
      if2.m1_we = 0;
   endtask

   // Async reset during an m0 write: ram_we falls without a clock, no rvalid later.
   task automatic test_reset_mid_access();
      nxt();
      if2.m0_req = 1; if2.m0_we = 1; if2.m0_addr = 32'h80; if2.m0_wdata = 32'h1234;
      #1;
      checks++;
      if (if2.m0_gnt !== 1'b1) begin
         errors++; $display("FAIL rst_mid_gnt got %b want 1", if2.m0_gnt);
      end
      nxt(); if2.m0_req = 0; if2.m0_we = 0; #1;
      checks++;
      if (if2.ram_we !== 1'b1) begin
         errors++; $display("FAIL rst_mid_we_before got %b want 1", if2.ram_we);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (if2.ram_we !== 1'b0) begin
         errors++; $display("FAIL rst_mid_we_drop got %b want 0", if2.ram_we);
      end
      nxt(); reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         nxt(); #1;
         checks++;
         if ({if2.m0_rvalid, if2.m1_rvalid} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_no_rvalid[%0d] got %b%b want 00", c, if2.m0_rvalid, if2.m1_rvalid);
         end
      end
   endtask

`ifdef MEM_ARB_LOCK_EN
   // m1: 3 locked reads then 1 unlocked while m0 waits -> m1 x4, then m0.
   task automatic test_lock();
      nxt();
      if2.m1_req = 1; if2.m1_we = 0; if2.m1_addr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         if2.m1_lock = (k < 3);
         #1;
         checks++;
         if ({if2.m1_gnt, if2.m0_gnt} !== 2'b10) begin
            errors++; $display("FAIL lock_gnt[%0d] got m1=%b m0=%b want 1 0", k, if2.m1_gnt, if2.m0_gnt);
         end
         nxt();
         if (k == 0) if2.m0_req = 1;
         if (k == 3) begin if2.m1_req = 0; if2.m1_lock = 0; end
         nxt(); nxt();
      end
      #1;
      checks++;
      if ({if2.m0_gnt, if2.m1_rvalid} !== 2'b11) begin
         errors++; $display("FAIL lock_release got m0_gnt=%b m1_rvalid=%b want 1 1", if2.m0_gnt, if2.m1_rvalid);
      end
      nxt(); if2.m0_req = 0;
      repeat (3) nxt();
   endtask
`endif

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_write_ack();
      test_reset_mid_access();
`ifdef MEM_ARB_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single RAM port between two requesters: master 0 is the multicycle CPU (fetch/load/store) and master 1 is a DMA/debug loader. It latches one request at a time and holds it on the RAM port for a fixed RAM latency. It then returns read data or a write acknowledge to the requester that owns the transaction. Arbitration is round-robin, so neither master can starve the other. The block sits between the CPU's `cpu_ram_*` outputs and the RAM model.

## Interface
Parameters:
- `RAM_LAT`, 1, RAM cycles from address valid to `ram_rdata` valid; legal range 1..4.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports (`mN_` = one identical set per master, N ∈ {0,1}):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mN_req`  in  1  request valid; must hold with fields stable until `mN_gnt`.
- `mN_we`  in  1  1 = write, 0 = read.
- `mN_addr`  in  ADDR_W  byte address.
- `mN_mask`  in  2  access-size mask, passed to RAM unmodified.
- `mN_signed_ext`  in  1  load sign-extend, passed unmodified.
- `mN_wdata`  in  DATA_W  write data.
- `mN_gnt`  out  1  request accepted this cycle.
- `mN_rvalid`  out  1  one-cycle completion pulse (read data or write ack).
- `mN_rdata`  out  DATA_W  read data, valid with `mN_rvalid`; 0 for writes.
- `ram_we`, `ram_addr`, `ram_mask`, `ram_signed_ext`, `ram_wdata`  out  1/ADDR_W/2/1/DATA_W  RAM port.
- `ram_rdata`  in  DATA_W  RAM read data.

## Operation
- FSM states:
  - IDLE: arbitrate and grant.
  - ACCESS: drive the RAM from latched fields for RAM_LAT cycles, using down-counter `lat_cnt`.
- Arbitration in IDLE:
  - Only one `req`: that master wins.
  - Both `req`: the master other than `last_gnt` wins.
  - `last_gnt` resets to 1, so m0 wins the first tie.
- Grant:
  - `mN_gnt` is combinational, high only in IDLE for the winner.
  - On that edge: latch the winner's we/addr/mask/signed_ext/wdata and owner id, update `last_gnt`, load `lat_cnt` = RAM_LAT−1, go to ACCESS.
- ACCESS:
  - `ram_addr`, `ram_mask`, `ram_signed_ext` and `ram_wdata` come from the latched registers.
  - `ram_we` is high only in the first ACCESS cycle, and only for a write.
  - When `lat_cnt` = 0: capture `ram_rdata` (reads) or 0 (writes) into the owner's `rdata` register, set the owner's `rvalid` for the next cycle, go to IDLE.
- The non-owner's `rvalid` is never asserted; its `rdata` holds its last value.
- A request arriving during ACCESS waits; `gnt` stays low.
- Outputs after reset: every output is 0. `last_gnt` = 1, state = IDLE.
- Async reset mid-ACCESS:
  - `ram_we` drops immediately.
  - The transaction is discarded; no `rvalid` is issued.

## Timing
- Grant cycle T (IDLE) → ACCESS for cycles T+1 … T+RAM_LAT → `rvalid` in cycle T+RAM_LAT+1.
- IDLE is re-entered in cycle T+RAM_LAT+1, so a new grant can coincide with the `rvalid` cycle.
- Sustained throughput: one transaction per RAM_LAT+1 cycles.
- Two masters continuously requesting alternate strictly: m0, m1, m0, …
- `gnt` and `rvalid` for the same master may be high in the same cycle, for back-to-back transactions.
- `ram_rdata` is sampled only on the last ACCESS cycle; it is don't-care otherwise.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - Adds input `mN_lock` (1 bit) per master.
  - If the winner's `lock` is high at grant, ownership is held: subsequent IDLE arbitration considers only the owner.
  - Ownership ends with the first granted owner request that has `lock` = 0. That access completes normally and `last_gnt` updates to the owner.
  - Reset clears ownership.
- `MEM_ARB_LOCK_EN` undefined: the ports are absent; behaviour is pure round-robin as above.

## Structure
- `mem_arb_pkg` holds:
  - state enum {ARB_IDLE, ARB_ACCESS};
  - master-id typedef (1 bit);
  - `MAX_RAM_LAT` = 4;
  - the `lat_cnt` width derived from `MAX_RAM_LAT`.
- Sub-module `rr_arbiter2`: two-way round-robin picker.
  - Inputs: req[1:0], last_gnt, plus lock/owner when `MEM_ARB_LOCK_EN` is defined.
  - Output: a one-hot grant.
  - Purely combinational; `last_gnt` is stored in the parent.

## Test plan
- Reset check, RAM_LAT=1: hold `reset`=0 with both reqs high → all outputs 0; release → m0 granted first, `m0_gnt`=1.
- Single read, RAM_LAT=2: m0 reads addr 0x100 with RAM returning 0xDEADBEEF → `ram_addr`=0x100 for 2 cycles, `m0_rvalid` at T+3, `m0_rdata`=0xDEADBEEF.
- Write ack: m1 writes 0x55AA to 0x40 → `ram_we` high exactly 1 cycle with `ram_wdata`=0x55AA; `m1_rvalid` pulse with `m1_rdata`=0.
- Contention, RAM_LAT=1: both masters request continuously for 8 transactions → grant order m0,m1,m0,m1…, one `rvalid` every 2 cycles, no starvation.
- Reset mid-ACCESS: assert `reset` during an m0 write → `ram_we` falls without a clock edge, and no `m0_rvalid` appears after release.
- Lock (`MEM_ARB_LOCK_EN`): m1 issues 3 locked reads then 1 unlocked read while m0 requests → m1 serviced 4 times in a row, then m0 granted.
